// File: rtl/morse_seq_builder.sv
// Morse front end: edge-detects Dot/Dash/Space/EndSeq keys and packs accepted
// Dot/Dash symbols into a 2-bit-per-slot word that is published on each terminator.
module morse_seq_builder #(
    parameter int MAX_SYM = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Clear,
    input  logic                   Dot,
    input  logic                   Dash,
    input  logic                   Space,
    input  logic                   EndSeq,
    output logic [2:0]             Signals,
    output logic [2*MAX_SYM-1:0]   EncSeq,
    output logic                   Space_EndSeqbar,
    output logic                   SeqValid,
    output logic [2:0]             SeqLen
);

    localparam int W     = 2 * MAX_SYM;
    localparam int CNT_W = $clog2(MAX_SYM + 1);

    localparam logic [2:0] SIG_NONE = 3'b000;
    localparam logic [2:0] SIG_DOT  = 3'b001;
    localparam logic [2:0] SIG_DASH = 3'b010;
    localparam logic [2:0] SIG_SPC  = 3'b011;
    localparam logic [2:0] SIG_END  = 3'b100;

    logic [3:0]       r_hist;
    logic [W-1:0]     r_buf;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_rise;
    logic [2:0]       w_code;
    logic [1:0]       w_slot;
    logic [W-1:0]     w_buf_wr;

    // Bit order {EndSeq, Space, Dash, Dot} matches the priority order below.
    assign w_rise = {EndSeq, Space, Dash, Dot} & ~r_hist;

    always_comb begin
        w_code = SIG_NONE;
        if (w_rise[3])      w_code = SIG_END;
        else if (w_rise[2]) w_code = SIG_SPC;
        else if (w_rise[1]) w_code = SIG_DASH;
        else if (w_rise[0]) w_code = SIG_DOT;
    end

    assign w_slot = (w_code == SIG_DASH) ? 2'b01 : 2'b00;

    always_comb begin
        w_buf_wr = r_buf;
        for (int i = 0; i < MAX_SYM; i++) begin
            if (r_cnt == CNT_W'(i))
                w_buf_wr[W-1-2*i -: 2] = w_slot;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hist          <= '0;
            r_buf           <= '1;
            r_cnt           <= '0;
            Signals         <= SIG_NONE;
            EncSeq          <= '1;
            Space_EndSeqbar <= 1'b0;
            SeqValid        <= 1'b0;
            SeqLen          <= '0;
        end else begin
            r_hist   <= {EndSeq, Space, Dash, Dot};
            SeqValid <= 1'b0;
            if (Clear) begin
                r_buf   <= '1;
                r_cnt   <= '0;
                Signals <= SIG_NONE;
                EncSeq  <= '1;
                SeqLen  <= '0;
            end else begin
                case (w_code)
                    SIG_DOT, SIG_DASH: begin
                        Signals <= w_code;
                        // A full buffer drops further symbols until a terminator.
                        if (r_cnt < CNT_W'(MAX_SYM)) begin
                            r_buf <= w_buf_wr;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    SIG_SPC, SIG_END: begin
                        Signals         <= w_code;
                        EncSeq          <= r_buf;
                        SeqLen          <= 3'(r_cnt);
                        Space_EndSeqbar <= (w_code == SIG_SPC);
                        SeqValid        <= 1'b1;
                        r_buf           <= '1;
                        r_cnt           <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_seq_builder.sv
// Directed bench for morse_seq_builder: one table row per clock cycle plus a
// hand-written reset-mid-character sequence.
module tb_morse_seq_builder;

    logic       Clk;
    logic       Reset;
    logic       Clear;
    logic       Dot;
    logic       Dash;
    logic       Space;
    logic       EndSeq;
    logic [2:0] Signals;
    logic [9:0] EncSeq;
    logic       Space_EndSeqbar;
    logic       SeqValid;
    logic [2:0] SeqLen;

    int n_cmp = 0;
    int n_err = 0;

    morse_seq_builder #(.MAX_SYM(5)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Clear           (Clear),
        .Dot             (Dot),
        .Dash            (Dash),
        .Space           (Space),
        .EndSeq          (EndSeq),
        .Signals         (Signals),
        .EncSeq          (EncSeq),
        .Space_EndSeqbar (Space_EndSeqbar),
        .SeqValid        (SeqValid),
        .SeqLen          (SeqLen)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       clr;
        logic       dot;
        logic       dash;
        logic       spc;
        logic       endq;
        logic [2:0] sig;
        logic [9:0] enc;
        logic       sev;
        logic       vld;
        logic [2:0] len;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic dot, input logic dash,
                       input logic spc, input logic endq, input logic [2:0] sig,
                       input logic [9:0] enc, input logic sev, input logic vld,
                       input logic [2:0] len);
        vec_t v;
        v.clr = clr; v.dot = dot; v.dash = dash; v.spc = spc; v.endq = endq;
        v.sig = sig; v.enc = enc; v.sev = sev; v.vld = vld; v.len = len;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] sig, input logic [9:0] enc,
                           input logic sev, input logic vld, input logic [2:0] len);
        chk({tag, " Signals"},         16'(Signals),         16'(sig));
        chk({tag, " EncSeq"},          16'(EncSeq),          16'(enc));
        chk({tag, " Space_EndSeqbar"}, 16'(Space_EndSeqbar), 16'(sev));
        chk({tag, " SeqValid"},        16'(SeqValid),        16'(vld));
        chk({tag, " SeqLen"},          16'(SeqLen),          16'(len));
    endtask

    task automatic drive(input logic clr, input logic dot, input logic dash,
                         input logic spc, input logic endq);
        Clear = clr; Dot = dot; Dash = dash; Space = spc; EndSeq = endq;
    endtask

    initial begin
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk_all("reset", 3'b000, 10'h3FF, 1'b0, 1'b0, 3'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Clear pulse
        add(1,0,0,0,0, 3'b000, 10'h3FF, 0, 0, 0);
        // Dot Dash Dot Dot Space
        add(0,1,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,0,1,0,0, 3'b010, 10'h3FF, 0, 0, 0);
        add(0,0,0,0,0, 3'b010, 10'h3FF, 0, 0, 0);
        add(0,1,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,1,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 0, 0, 0);
        add(0,0,0,1,0, 3'b011, 10'h043, 1, 1, 4);
        add(0,0,0,0,0, 3'b011, 10'h043, 1, 0, 4);
        // Word gap
        add(0,0,0,1,0, 3'b011, 10'h3FF, 1, 1, 0);
        add(0,0,0,0,0, 3'b011, 10'h3FF, 1, 0, 0);
        // Dot Dash Dot Dot EndSeq
        add(0,1,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,1,0,0, 3'b010, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b010, 10'h3FF, 1, 0, 0);
        add(0,1,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,1,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,1, 3'b100, 10'h043, 0, 1, 4);
        add(0,0,0,0,0, 3'b100, 10'h043, 0, 0, 4);
        // Six dashes, sixth ignored
        for (int i = 0; i < 6; i++) begin
            add(0,0,1,0,0, 3'b010, 10'h043, 0, 0, 4);
            add(0,0,0,0,0, 3'b010, 10'h043, 0, 0, 4);
        end
        add(0,0,0,1,0, 3'b011, 10'h155, 1, 1, 5);
        add(0,0,0,0,0, 3'b011, 10'h155, 1, 0, 5);
        // Dot held for 10 cycles counts once
        for (int i = 0; i < 10; i++)
            add(0,1,0,0,0, 3'b001, 10'h155, 1, 0, 5);
        add(0,0,0,0,0, 3'b001, 10'h155, 1, 0, 5);
        add(0,0,0,1,0, 3'b011, 10'h0FF, 1, 1, 1);
        add(0,0,0,0,0, 3'b011, 10'h0FF, 1, 0, 1);
        // Dot and Dash together: Dash wins
        add(0,1,1,0,0, 3'b010, 10'h0FF, 1, 0, 1);
        add(0,0,0,0,0, 3'b010, 10'h0FF, 1, 0, 1);
        add(0,0,0,1,0, 3'b011, 10'h1FF, 1, 1, 1);
        add(0,0,0,0,0, 3'b011, 10'h1FF, 1, 0, 1);
        // Clear together with Space drops the terminator; held Space gives no late event
        add(0,1,0,0,0, 3'b001, 10'h1FF, 1, 0, 1);
        add(1,0,0,1,0, 3'b000, 10'h3FF, 1, 0, 0);
        add(0,0,0,1,0, 3'b000, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b000, 10'h3FF, 1, 0, 0);
        // Space and EndSeq together: EndSeq wins
        add(0,1,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,0,0, 3'b001, 10'h3FF, 1, 0, 0);
        add(0,0,0,1,1, 3'b100, 10'h0FF, 0, 1, 1);
        add(0,0,0,0,0, 3'b100, 10'h0FF, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].dot, vecs[i].dash, vecs[i].spc, vecs[i].endq);
            @(posedge Clk); #1;
            chk_all($sformatf("row%0d", i), vecs[i].sig, vecs[i].enc,
                    vecs[i].sev, vecs[i].vld, vecs[i].len);
        end

        // Reset mid-character: two symbols in, then async reset
        drive(0,1,0,0,0); @(posedge Clk); #1;
        drive(0,0,0,0,0); @(posedge Clk); #1;
        drive(0,0,1,0,0); @(posedge Clk); #1;
        drive(0,0,0,0,0); @(posedge Clk); #1;
        chk("pre-reset Signals", 16'(Signals), 16'h2);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("midreset", 3'b000, 10'h3FF, 1'b0, 1'b0, 3'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        drive(0,0,0,1,0); @(posedge Clk); #1;
        chk_all("post-reset space", 3'b011, 10'h3FF, 1'b1, 1'b1, 3'd0);
        drive(0,0,0,0,0); @(posedge Clk); #1;
        chk("post-reset SeqValid drop", 16'(SeqValid), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
